// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner: debounce FSM states,
// internal key-index type with its NONE encoding, and the key-code width helper.
package keypad_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_e;

  // Internal key index is wide enough for an 8x8 matrix plus a spare code,
  // so NONE never collides with a real key whatever ROWS/COLS are.
  localparam int KEY_IDX_W = 7;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;
  localparam key_idx_t KEY_NONE = '1;

  // Width of the external key_code port for a matrix of n_keys keys.
  function automatic int key_code_width(input int n_keys);
    return (n_keys > 2) ? $clog2(n_keys) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM for the keypad scanner. Consumes one frame result
// per frame-close strobe and raises a one-cycle event strobe when a press
// (and, with KEYPAD_RELEASE_EVENT_EN defined, a release) has been stable for
// DEBOUNCE consecutive frames. Without the macro the release transition still
// happens but produces no event.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     frame_i,
  input  key_idx_t key_i,
  output logic     evt_o,
  output key_idx_t evt_key_o,
  output logic     evt_release_o
);

  localparam logic [3:0] DEB_N      = 4'(DEBOUNCE);
  localparam bit         FIRST_DONE = (DEBOUNCE == 1);

  deb_state_e state_q;
  logic [3:0] count_q;
  key_idx_t   cand_q;      // candidate key while debouncing a press, held key otherwise

  logic [3:0] count_inc;
  logic       press_done;
  logic       rel_done;

  assign count_inc = count_q + 4'd1;

  // Decide, at frame close, whether this frame completes a press or a release.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    press_done = 1'b0;
    rel_done   = 1'b0;
    evt_key_o  = cand_q;
    if (frame_i) begin
      unique case (state_q)
        IDLE: begin
          if (key_i != KEY_NONE && FIRST_DONE) begin
            press_done = 1'b1;
            evt_key_o  = key_i;
          end
        end
        DEB_PRESS: begin
          if (key_i != KEY_NONE) begin
            if (key_i == cand_q) begin
              press_done = (count_inc >= DEB_N);
            end else if (FIRST_DONE) begin
              press_done = 1'b1;
              evt_key_o  = key_i;
            end
          end
        end
        HELD: begin
          rel_done = (key_i != cand_q) && FIRST_DONE;
        end
        DEB_RELEASE: begin
          rel_done = (key_i != cand_q) && (count_inc >= DEB_N);
        end
        default: ;
      endcase
    end
  end

  // Debounce state machine; state and stability count move only at frame close.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      cand_q  <= KEY_NONE;
    end else if (frame_i) begin
      unique case (state_q)
        IDLE: begin
          if (key_i != KEY_NONE) begin
            cand_q  <= key_i;
            state_q <= press_done ? HELD : DEB_PRESS;
            count_q <= press_done ? 4'd0 : 4'd1;
          end
        end
        DEB_PRESS: begin
          if (key_i == KEY_NONE) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            cand_q  <= KEY_NONE;
          end else if (key_i == cand_q) begin
            state_q <= press_done ? HELD : DEB_PRESS;
            count_q <= press_done ? 4'd0 : count_inc;
          end else begin
            cand_q  <= key_i;
            state_q <= press_done ? HELD : DEB_PRESS;
            count_q <= press_done ? 4'd0 : 4'd1;
          end
        end
        HELD: begin
          if (key_i != cand_q) begin
            state_q <= rel_done ? IDLE : DEB_RELEASE;
            count_q <= rel_done ? 4'd0 : 4'd1;
            if (rel_done) cand_q <= KEY_NONE;
          end
        end
        DEB_RELEASE: begin
          if (key_i == cand_q) begin
            state_q <= HELD;
            count_q <= 4'd0;
          end else if (rel_done) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            cand_q  <= KEY_NONE;
          end else begin
            count_q <= count_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  assign evt_o         = press_done | rel_done;
  assign evt_release_o = rel_done;
`else
  assign evt_o         = press_done;
  assign evt_release_o = 1'b0;
`endif

endmodule

// File: rtl/keypad_matrix_scan.sv
// Keypad matrix scanner: clock divider, one-hot row rotation, per-frame key
// accumulation with ghost rejection, debounce (keypad_debounce) and a one-deep
// valid/ready event register with overflow indication.
// Optional macro KEYPAD_RELEASE_EVENT_EN enables release events (see keypad_debounce).
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 3,
  parameter  int CLK_DIV  = 2500,
  parameter  int DEBOUNCE = 4,
  localparam int KEY_W    = key_code_width(ROWS * COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS-1:0]        in_from_keypad,
  output logic [ROWS-1:0]        out_to_keypad,
  output logic [KEY_W-1:0]       key_code,
  output logic [ROWS*COLS-1:0]   key_onehot,
  output logic                   key_release,
  output logic                   valid,
  input  logic                   ready,
  output logic                   overflow
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int ROW_W = $clog2(ROWS);

  logic [CNT_W-1:0] div_q;
  logic [ROWS-1:0]  row_q;
  logic [ROW_W-1:0] row_idx_q;
  logic [1:0]       acc_hits_q;   // asserted bits so far this frame, saturating at 2
  key_idx_t         acc_key_q;

  logic             tick;
  logic             last_row;
  logic             frame_close;
  logic [1:0]       row_hits;
  key_idx_t         row_key;
  logic [2:0]       hit_sum;
  logic [1:0]       frame_hits;
  key_idx_t         frame_key_sel;
  key_idx_t         frame_key;

  logic             evt;
  key_idx_t         evt_key;
  logic             evt_release;

  logic [KEY_W-1:0] key_code_q;
  logic [NKEYS-1:0] key_onehot_q;
  logic             key_release_q;
  logic             valid_q;
  logic             overflow_q;

  assign tick        = (div_q == CNT_W'(CLK_DIV - 1));
  assign last_row    = (row_idx_q == ROW_W'(ROWS - 1));
  assign frame_close = tick & last_row;

  // Decode the column sense for the driven row and merge it into the frame result.
  always_comb begin
    row_hits = 2'd0;
    row_key  = KEY_NONE;
    for (int c = 0; c < COLS; c++) begin
      // Column 0 arrives on the MSB of in_from_keypad.
      if (in_from_keypad[COLS-1-c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_key = key_idx_t'(int'(row_idx_q) * COLS + c);
      end
    end
    hit_sum       = {1'b0, acc_hits_q} + {1'b0, row_hits};
    frame_hits    = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    frame_key_sel = (acc_hits_q == 2'd1) ? acc_key_q : row_key;
    // Zero hits and two-or-more hits (ghosting) both report NONE.
    frame_key     = (frame_hits == 2'd1) ? frame_key_sel : KEY_NONE;
  end

  // Divider, row rotation and frame accumulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      row_q      <= ROWS'(1);
      row_idx_q  <= '0;
      acc_hits_q <= 2'd0;
      acc_key_q  <= KEY_NONE;
    end else if (tick) begin
      div_q <= '0;
      row_q <= {row_q[ROWS-2:0], row_q[ROWS-1]};
      if (last_row) begin
        row_idx_q  <= '0;
        acc_hits_q <= 2'd0;
        acc_key_q  <= KEY_NONE;
      end else begin
        row_idx_q  <= row_idx_q + ROW_W'(1);
        acc_hits_q <= frame_hits;
        acc_key_q  <= frame_key_sel;
      end
    end else begin
      div_q <= div_q + CNT_W'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .frame_i       (frame_close),
    .key_i         (frame_key),
    .evt_o         (evt),
    .evt_key_o     (evt_key),
    .evt_release_o (evt_release)
  );

  // One-deep event register: a new event loads if the slot is free or being
  // consumed this cycle, otherwise it is dropped and overflow pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      key_code_q    <= '0;
      key_onehot_q  <= '0;
      key_release_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (evt) begin
        if (!valid_q || ready) begin
          valid_q       <= 1'b1;
          key_code_q    <= KEY_W'(evt_key);
          key_onehot_q  <= NKEYS'(1) << evt_key;
          key_release_q <= evt_release;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q      <= 1'b0;
        key_onehot_q <= '0;
      end
    end
  end

  assign out_to_keypad = row_q;
  assign key_code      = key_code_q;
  assign key_onehot    = key_onehot_q;
  assign key_release   = key_release_q;
  assign valid         = valid_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Scoreboard bench for keypad_matrix_scan (ROWS=4, COLS=3, CLK_DIV=4, DEBOUNCE=2).
// A keypad model drives the columns from a pressed-key mask; the stimulus
// thread pushes expected events, a monitor pops them when valid&ready.
module tb_keypad_matrix_scan;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 3;

  typedef struct packed {
    logic [3:0] code;
    logic       rel;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_from_keypad;
  logic [3:0]  out_to_keypad;
  logic [3:0]  key_code;
  logic [11:0] key_onehot;
  logic        key_release;
  logic        valid;
  logic        ready;
  logic        overflow;

  logic [11:0] keys;
  evt_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          ovf_seen = 0;
  int          exp_ovf = 0;

  keypad_matrix_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .CLK_DIV  (4),
    .DEBOUNCE (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_from_keypad (in_from_keypad),
    .out_to_keypad  (out_to_keypad),
    .key_code       (key_code),
    .key_onehot     (key_onehot),
    .key_release    (key_release),
    .valid          (valid),
    .ready          (ready),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row to its column; column 0 is the MSB.
  always_comb begin
    in_from_keypad = 3'b000;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (out_to_keypad[r] && keys[r*COLS+c]) in_from_keypad[COLS-1-c] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Returns at the first negedge of a new frame (row drive just wrapped 1000 -> 0001).
  task automatic wait_frame();
    logic [3:0] prev;
    @(negedge clk);
    prev = out_to_keypad;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (prev == 4'b1000 && out_to_keypad == 4'b0001) return;
      prev = out_to_keypad;
    end
    total++;
    bad++;
    $display("FAIL frame_timeout: got no row wrap within 40 cycles want one");
  endtask

  task automatic push_evt(input int code, input logic rel);
    evt_t e;
    e.code = 4'(code);
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (overflow) ovf_seen++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got code=%0d rel=%0b want no event", key_code, key_release);
        end else begin
          evt_t e;
          logic [11:0] oh;
          e  = exp_q.pop_front();
          oh = 12'd1 << e.code;
          check("evt_code", 32'(key_code), 32'(e.code));
          check("evt_onehot", 32'(key_onehot), 32'(oh));
          check("evt_release", 32'(key_release), 32'(e.rel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    ready = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rows", 32'(out_to_keypad), 32'h1);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_onehot", 32'(key_onehot), 32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_state", 32'(dut.u_debounce.state_q), 32'(IDLE));
    rst = 1'b1;
    wait_frame();

    // Key 4 (row 1, column 1) held for 4 frames: one press, valid after frame 2.
    wait_frame();
    keys = 12'd1 << 4;
    push_evt(4, 1'b0);
    wait_frame();
    check("t1_valid_f1", 32'(valid), 32'h0);
    wait_frame();
    check("t1_valid_f2", 32'(valid), 32'h1);
    check("t1_code", 32'(key_code), 32'd4);
    check("t1_onehot", 32'(key_onehot), 32'h010);
    repeat (2) wait_frame();
    keys = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    push_evt(4, 1'b1);
`endif
    repeat (3) wait_frame();

    // Single-frame blip: no event, back to IDLE.
    wait_frame();
    keys = 12'd1 << 4;
    wait_frame();
    keys = '0;
    repeat (2) wait_frame();
    check("t2_state", 32'(dut.u_debounce.state_q), 32'(IDLE));

    // Ghosting: keys 0 and 8 together produce nothing.
    wait_frame();
    keys = (12'd1 << 0) | (12'd1 << 8);
    repeat (3) wait_frame();
    check("t3_state", 32'(dut.u_debounce.state_q), 32'(IDLE));
    keys = '0;
    wait_frame();

    // Backpressure: key 2 held in the register, key 7 dropped with overflow.
    ready = 1'b0;
    wait_frame();
    keys = 12'd1 << 2;
    push_evt(2, 1'b0);
    repeat (2) wait_frame();
    keys = 12'd1 << 7;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_ovf++;
`endif
    exp_ovf++;
    repeat (5) wait_frame();
    check("t4_valid_held", 32'(valid), 32'h1);
    check("t4_code_held", 32'(key_code), 32'd2);
    check("t4_onehot_held", 32'(key_onehot), 32'h004);
    check("t4_overflow_cnt", 32'(ovf_seen), 32'(exp_ovf));
    @(posedge clk);
    #1 ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_valid_cleared", 32'(valid), 32'h0);
    check("t4_onehot_cleared", 32'(key_onehot), 32'h0);
`ifdef KEYPAD_RELEASE_EVENT_EN
    push_evt(7, 1'b1);
`endif
    keys = '0;
    repeat (4) wait_frame();

    // Reset in DEB_PRESS discards the partial press.
    wait_frame();
    keys = 12'd1 << 5;
    wait_frame();
    check("t5_deb_state", 32'(dut.u_debounce.state_q), 32'(DEB_PRESS));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    keys = '0;
    @(posedge clk);
    #1;
    check("t5_rows", 32'(out_to_keypad), 32'h1);
    check("t5_valid", 32'(valid), 32'h0);
    check("t5_state", 32'(dut.u_debounce.state_q), 32'(IDLE));
    rst = 1'b1;
    repeat (3) wait_frame();

    // Key 11 held then released.
    wait_frame();
    keys = 12'd1 << 11;
    push_evt(11, 1'b0);
    repeat (3) wait_frame();
    keys = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    push_evt(11, 1'b1);
`endif
    repeat (3) wait_frame();

    // Release bounce: key 3 drops for one frame and returns, no extra event.
    wait_frame();
    keys = 12'd1 << 3;
    push_evt(3, 1'b0);
    repeat (2) wait_frame();
    keys = '0;
    wait_frame();
    keys = 12'd1 << 3;
    wait_frame();
    check("t7_rehold", 32'(dut.u_debounce.state_q), 32'(HELD));
    wait_frame();
    keys = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    push_evt(3, 1'b1);
`endif
    repeat (3) wait_frame();
    check("t7_state", 32'(dut.u_debounce.state_q), 32'(IDLE));

    check("pending_events", 32'(exp_q.size()), 32'h0);
    check("overflow_total", 32'(ovf_seen), 32'(exp_ovf));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scan.md
KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

Interface
REQ-001 Parameter ROWS, default 4, number of driven keypad rows (2..8).
REQ-002 Parameter COLS, default 3, number of sensed keypad columns (2..8).
REQ-003 Parameter CLK_DIV, default 2500, clk cycles per row slot (>=2).
REQ-004 Parameter DEBOUNCE, default 4, consecutive identical frames required to accept a change (1..15).
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 in_from_keypad  input  COLS  column sense; bit COLS-1 is column 0.
REQ-008 out_to_keypad  output  ROWS  one-hot row drive; bit r drives row r.
REQ-009 key_code  output  clog2(ROWS*COLS)  event key index = row*COLS + column.
REQ-010 key_onehot  output  ROWS*COLS  one-hot of key_code; all zero when valid is 0.
REQ-011 key_release  output  1  event is a release (1) or a press (0).
REQ-012 valid  output  1  event available.
REQ-013 ready  input  1  consumer accepts the event.
REQ-014 overflow  output  1  one-cycle pulse when an event is dropped.

Function
REQ-015 Tick counter counts 0..CLK_DIV-1 and wraps; tick = last count.
REQ-016 On tick: sample in_from_keypad against the currently driven row, then rotate out_to_keypad one position (row ROWS-1 wraps to row 0).
REQ-017 Frame = ROWS consecutive ticks, rows 0..ROWS-1; the frame closes on the row ROWS-1 tick.
REQ-018 Frame result: exactly one asserted bit across the frame = candidate key; zero bits = NONE; two or more bits = NONE (ghost rejection).
REQ-019 FSM states IDLE, DEB_PRESS, HELD, DEB_RELEASE; state and 4-bit stability count update only at frame close.
REQ-020 IDLE: candidate key -> DEB_PRESS with count=1; NONE stays IDLE.
REQ-021 DEB_PRESS: same key -> count+1; count reaching DEBOUNCE -> HELD with a press event; different key restarts count=1 with that key; NONE -> IDLE.
REQ-022 HELD: same key stays; any other result -> DEB_RELEASE with count=1.
REQ-023 DEB_RELEASE: non-held result -> count+1; count reaching DEBOUNCE -> IDLE with a release event; held key reappears -> HELD with no event.
REQ-024 DEBOUNCE=1 accepts a change on the first frame that shows it.
REQ-025 Event latency: valid, key_code, key_onehot and key_release update on the cycle after the frame-close tick.
REQ-026 Output register is one deep: it holds its values while valid=1 and ready=0; valid&ready clears valid on the next cycle.
REQ-027 New event while valid=1 and ready=0: new event dropped, overflow pulses one cycle, and the held event is unchanged.
REQ-028 New event on the same cycle as valid&ready: the new event loads and valid stays 1 with no overflow.
REQ-029 No auto-repeat: a held key produces exactly one press event.

Reset
REQ-030 rst=0 at a clk edge: tick counter=0, out_to_keypad=1 (row 0), FSM=IDLE, count=0, valid=0, key_code=0, key_onehot=0, key_release=0, overflow=0.
REQ-031 Reset mid-frame or mid-debounce discards all partial frame and debounce state.

Configuration
REQ-032 Macro KEYPAD_RELEASE_EVENT_EN: when defined, DEB_RELEASE->IDLE emits a release event with key_release=1 and key_code = the released key.
REQ-033 Without it, the transition emits no event, key_release is tied to 0, and the state transitions are unchanged.

Structure
REQ-034 Shared package keypad_pkg holds the FSM state enum, the key-index width function and the NONE encoding.
REQ-035 Sub-module keypad_debounce holds the FSM and count; the top holds the divider, row rotation, frame accumulation and output register.

Verification (ROWS=4, COLS=3, CLK_DIV=4, DEBOUNCE=2)
REQ-036 Column 1 asserted (in=3'b010) while row 1 is driven, held for 4 frames -> exactly one event, key_code=4, key_onehot=12'h010, key_release=0, valid one cycle after the close of frame 2.
REQ-037 Same key present for one frame only, then NONE -> no event, FSM back to IDLE.
REQ-038 Keys 0 and 8 asserted in the same frames -> no event (ghost rejection).
REQ-039 ready=0, press key 2 then press key 7 -> key_code remains 2, one overflow pulse; after ready=1 the event is consumed and valid=0.
REQ-040 rst=0 during DEB_PRESS -> next cycle out_to_keypad=4'b0001, valid=0, and no event for the interrupted press.
REQ-041 With KEYPAD_RELEASE_EVENT_EN, key 11 held then released for 2 frames -> press event, then release event with key_code=11, key_release=1; without the macro -> press event only.
